// File: rtl/decofer_pkg.sv
// Shared types and constants for the decofer seven-segment decoder.
// All glyph constants are active-high, bit order g f e d c b a.
package decofer_pkg;

  typedef logic [6:0] seg_t;

  // Segment bit positions within seg_t
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Decimal glyphs
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;

  // Dash is segment g alone; blank is every segment off
  localparam seg_t SEG_DASH  = seg_t'(1) << SEG_G;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/decofer_lut.sv
// Combinational BCD code to active-high segment pattern table.
// Codes 10-15 are replaced by INVALID_GLYPH.
module decofer_lut
  import decofer_pkg::*;
#(
  parameter seg_t INVALID_GLYPH = SEG_DASH
) (
  input  logic [3:0] i_code,
  output seg_t       o_seg
);

  // Glyph lookup; anything outside 0-9 shows the invalid glyph
  always_comb begin
    o_seg = INVALID_GLYPH;
    case (i_code)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = INVALID_GLYPH;
    endcase
  end

endmodule

// File: rtl/decofer.sv
// Registered BCD-to-seven-segment decoder. One cycle latency, output
// driven straight from a register. COMMON_CATHODE=0 inverts every
// registered pattern, blank included, for common-anode displays.
module decofer
  import decofer_pkg::*;
#(
  parameter bit   COMMON_CATHODE = 1'b1,
  parameter seg_t INVALID_GLYPH  = SEG_DASH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  output logic [6:0] out
);

  seg_t w_seg;
  seg_t w_drive;
  seg_t w_blank;
  seg_t r_out;

  decofer_lut #(
    .INVALID_GLYPH (INVALID_GLYPH)
  ) u_lut (
    .i_code (in),
    .o_seg  (w_seg)
  );

  // Apply display polarity before the register so out is a pure flop output
  always_comb begin
    w_drive = COMMON_CATHODE ? w_seg     : ~w_seg;
    w_blank = COMMON_CATHODE ? SEG_BLANK : ~SEG_BLANK;
  end

  // Output register: blank on reset, otherwise the decoded glyph
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out <= w_blank;
    end else begin
      r_out <= w_drive;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_decofer.sv
// Scoreboard bench for decofer: common-cathode and common-anode instances
// share the same stimulus; expected patterns are queued on issue and
// popped by an independent monitor one edge later.
module tb_decofer;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic [6:0] out_cc;
  logic [6:0] out_ca;

  int checks;
  int errors;

  logic [6:0] q_cc[$];
  logic [6:0] q_ca[$];
  string      q_nm[$];

  decofer #(.COMMON_CATHODE(1'b1), .INVALID_GLYPH(7'h40)) dut_cc (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (din),
    .out   (out_cc)
  );

  decofer #(.COMMON_CATHODE(1'b0), .INVALID_GLYPH(7'h40)) dut_ca (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (din),
    .out   (out_ca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written reference glyphs, active-high
  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: ref_seg = 7'h3F;
      4'd1: ref_seg = 7'h06;
      4'd2: ref_seg = 7'h5B;
      4'd3: ref_seg = 7'h4F;
      4'd4: ref_seg = 7'h66;
      4'd5: ref_seg = 7'h6D;
      4'd6: ref_seg = 7'h7D;
      4'd7: ref_seg = 7'h07;
      4'd8: ref_seg = 7'h7F;
      4'd9: ref_seg = 7'h6F;
      default: ref_seg = 7'h40;
    endcase
  endfunction

  // Drive one cycle of stimulus and queue what each instance must show after the next edge
  task automatic step(input logic r, input logic [3:0] v,
                      input logic [6:0] e_cc, input logic [6:0] e_ca,
                      input string nm);
    @(negedge clk);
    rst_n = r;
    din   = v;
    q_cc.push_back(e_cc);
    q_ca.push_back(e_ca);
    q_nm.push_back(nm);
  endtask

  // Monitor: just after each rising edge, compare against the oldest queued entry
  initial begin : monitor
    logic [6:0] e_cc;
    logic [6:0] e_ca;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (q_cc.size() != 0) begin
        e_cc = q_cc.pop_front();
        e_ca = q_ca.pop_front();
        nm   = q_nm.pop_front();
        checks++;
        if (out_cc !== e_cc) begin
          errors++;
          $display("FAIL %s cc: got %h expected %h", nm, out_cc, e_cc);
        end
        checks++;
        if (out_ca !== e_ca) begin
          errors++;
          $display("FAIL %s ca: got %h expected %h", nm, out_ca, e_ca);
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0] v;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    din    = 4'd8;

    // Reset held with in=8, then release
    for (int i = 0; i < 5; i++) step(1'b0, 4'd8, 7'h00, 7'h7F, "reset");
    step(1'b1, 4'd8, 7'h7F, 7'h00, "release8");

    // Valid sweep 0..9
    step(1'b1, 4'd0, 7'h3F, 7'h40, "sweep0");
    step(1'b1, 4'd1, 7'h06, 7'h79, "sweep1");
    step(1'b1, 4'd2, 7'h5B, 7'h24, "sweep2");
    step(1'b1, 4'd3, 7'h4F, 7'h30, "sweep3");
    step(1'b1, 4'd4, 7'h66, 7'h19, "sweep4");
    step(1'b1, 4'd5, 7'h6D, 7'h12, "sweep5");
    step(1'b1, 4'd6, 7'h7D, 7'h02, "sweep6");
    step(1'b1, 4'd7, 7'h07, 7'h78, "sweep7");
    step(1'b1, 4'd8, 7'h7F, 7'h00, "sweep8");
    step(1'b1, 4'd9, 7'h6F, 7'h10, "sweep9");

    // Invalid codes show the dash, then a valid digit recovers
    for (int c = 10; c < 16; c++) step(1'b1, 4'(c), 7'h40, 7'h3F, "invalid");
    step(1'b1, 4'd9, 7'h6F, 7'h10, "after_inv");

    // Stable input holds steady
    for (int i = 0; i < 3; i++) step(1'b1, 4'd4, 7'h66, 7'h19, "stable4");

    // Random digits 0-9
    for (int i = 0; i < 64; i++) begin
      v = 4'($urandom_range(9, 0));
      step(1'b1, v, ref_seg(v), ~ref_seg(v), "random");
    end

    // Mid-stream reset pulse
    step(1'b1, 4'd3, 7'h4F, 7'h30, "mid3");
    step(1'b1, 4'd5, 7'h6D, 7'h12, "mid5");
    step(1'b0, 4'd7, 7'h00, 7'h7F, "mid_rst");
    step(1'b1, 4'd2, 7'h5B, 7'h24, "mid2");

    // Polarity directed points (reset, 0, 1, 12)
    step(1'b0, 4'd5, 7'h00, 7'h7F, "pol_rst");
    step(1'b1, 4'd0, 7'h3F, 7'h40, "pol0");
    step(1'b1, 4'd1, 7'h06, 7'h79, "pol1");
    step(1'b1, 4'd12, 7'h40, 7'h3F, "pol12");

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && q_cc.size() != 0; i++) @(negedge clk);
    checks++;
    if (q_cc.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q_cc.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
